// File: rtl/wb_trace_pkg.sv
// ---------------------------------------------------------------------------
// wb_trace_pkg
// Shared types and field widths for the writeback trace FIFO.
// One trace_entry_t holds a single retired register-write event, packed as
// {pc, rf_wen, rf_wnum, rf_wdata} = 73 bits.
// ---------------------------------------------------------------------------
package wb_trace_pkg;

  localparam int TRACE_PC_W   = 32;
  localparam int TRACE_WEN_W  = 4;
  localparam int TRACE_WNUM_W = 5;
  localparam int TRACE_DATA_W = 32;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_WEN_W-1:0]  rf_wen;
    logic [TRACE_WNUM_W-1:0] rf_wnum;
    logic [TRACE_DATA_W-1:0] rf_wdata;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_ram.sv
// ---------------------------------------------------------------------------
// wb_trace_ram
// DEPTH x trace_entry_t storage.
// It has one synchronous write port and one asynchronous read port.
// The array has no reset.
//   clk      : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : entry to store
//   raddr_i  : read address (combinational read)
//   rdata_o  : entry at raddr_i
// ---------------------------------------------------------------------------
module wb_trace_ram
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t  rdata_o
);

  trace_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// wb_trace_fifo
// This block captures every retired register-write event from the CPU
// writeback trace port. Events are stored in a circular buffer and presented
// on a show-ahead valid/ready stream. The block also reports occupancy and a
// sticky overflow flag.
//
// Build option: define WB_TRACE_FIFO_X0_FILTER_EN to drop writes to r0
// (in_rf_wnum == 0) before they reach the buffer.
//
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   clear                 : synchronous flush of buffer and overflow flag
//   in_pc/in_rf_wen/in_rf_wnum/in_rf_wdata : trace input; wen != 0 is an event
//   out_valid/out_ready   : head-entry handshake
//   out_pc/out_rf_wen/out_rf_wnum/out_rf_wdata : head entry, 0 when not valid
//   count                 : occupancy 0..DEPTH
//   full                  : count == DEPTH
//   overflow              : sticky, set when an event is dropped
// ---------------------------------------------------------------------------
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic [TRACE_PC_W-1:0]   in_pc,
  input  logic [TRACE_WEN_W-1:0]  in_rf_wen,
  input  logic [TRACE_WNUM_W-1:0] in_rf_wnum,
  input  logic [TRACE_DATA_W-1:0] in_rf_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TRACE_PC_W-1:0]   out_pc,
  output logic [TRACE_WEN_W-1:0]  out_rf_wen,
  output logic [TRACE_WNUM_W-1:0] out_rf_wnum,
  output logic [TRACE_DATA_W-1:0] out_rf_wdata,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             pop;
  logic             wr_en;
  logic             empty_w;
  logic             full_w;
  logic [PTR_W-1:0] occ_w;
  trace_entry_t     wr_entry;
  trace_entry_t     rd_entry;

`ifdef WB_TRACE_FIFO_X0_FILTER_EN
  assign push_req = (in_rf_wen != '0) && (in_rf_wnum != '0);
`else
  assign push_req = (in_rf_wen != '0);
`endif

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occ_w   = wr_ptr_q - rd_ptr_q;

  // All status outputs come only from registered state. They never depend on out_ready.
  assign out_valid = !empty_w;
  assign full      = full_w;
  assign count     = CNT_W'(occ_w);
  assign overflow  = overflow_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (clear) begin
      // A flush wins over any push or pop in the same cycle.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_req) begin
        // When the FIFO is full, a pop in the same cycle frees the slot being written.
        if (!full_w || pop) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry = '{pc: in_pc, rf_wen: in_rf_wen, rf_wnum: in_rf_wnum,
                      rf_wdata: in_rf_wdata};

  wb_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // Mask the head fields so that the outputs never show stale or
  // uninitialised storage.
  assign out_pc       = out_valid ? rd_entry.pc       : '0;
  assign out_rf_wen   = out_valid ? rd_entry.rf_wen   : '0;
  assign out_rf_wnum  = out_valid ? rd_entry.rf_wnum  : '0;
  assign out_rf_wdata = out_valid ? rd_entry.rf_wdata : '0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_fifo
// Self-checking bench for wb_trace_fifo. A queue-based reference model holds
// the expected buffer contents and overflow flag. Inputs are driven on the
// falling edge, and outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic             clear;
  logic [31:0]      in_pc;
  logic [3:0]       in_rf_wen;
  logic [4:0]       in_rf_wnum;
  logic [31:0]      in_rf_wdata;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [3:0]       out_rf_wen;
  logic [4:0]       out_rf_wnum;
  logic [31:0]      out_rf_wdata;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {pc, wen, wnum, wdata} plus the sticky flag.
  logic [72:0] mq[$];
  logic        m_ov;

  wire [7:0]  dut_stat = {out_valid, full, overflow, count};
  wire [72:0] dut_head = {out_pc, out_rf_wen, out_rf_wnum, out_rf_wdata};

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .clear        (clear),
    .in_pc        (in_pc),
    .in_rf_wen    (in_rf_wen),
    .in_rf_wnum   (in_rf_wnum),
    .in_rf_wdata  (in_rf_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rf_wen   (out_rf_wen),
    .out_rf_wnum  (out_rf_wnum),
    .out_rf_wdata (out_rf_wdata),
    .count        (count),
    .full         (full),
    .overflow     (overflow)
  );

  function automatic logic [7:0] exp_stat();
    logic [CNT_W-1:0] c;
    c = CNT_W'(mq.size());
    return {mq.size() != 0, mq.size() == DEPTH, m_ov, c};
  endfunction

  function automatic logic [72:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 73'd0;
  endfunction

  task automatic drive(input logic clr, input logic [31:0] pc, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] wd, input logic rdy);
    clear       = clr;
    in_pc       = pc;
    in_rf_wen   = wen;
    in_rf_wnum  = wnum;
    in_rf_wdata = wd;
    out_ready   = rdy;
  endtask

  // Advance one clock and apply the behavioural rules to the model.
  task automatic cycle();
    bit push, pop;
    @(posedge clk);
    pop  = (mq.size() != 0) && out_ready;
    push = (in_rf_wen != 4'd0);
`ifdef WB_TRACE_FIFO_X0_FILTER_EN
    push = push && (in_rf_wnum != 5'd0);
`endif
    if (clear) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back({in_pc, in_rf_wen, in_rf_wnum, in_rf_wdata});
        else m_ov = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    mq.delete();
    m_ov = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (dut_stat !== 8'd0) begin
      errors++;
      $display("FAIL reset_stat got %h exp %h", dut_stat, 8'd0);
    end
    checks++;
    if (dut_head !== 73'd0) begin
      errors++;
      $display("FAIL reset_head got %h exp 0", dut_head);
    end
  endtask

  task automatic test_single();
    drive(0, 32'h1C000000, 4'hF, 5'd5, 32'hDEADBEEF, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_head !== {32'h1C000000, 4'hF, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_head got %h exp %h", dut_head, {32'h1C000000, 4'hF, 5'd5, 32'hDEADBEEF});
    end
    checks++;
    if (dut_stat !== {1'b1, 1'b0, 1'b0, 5'd1} || exp_stat() !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL single_stat got %h exp %h", dut_stat, {1'b1, 1'b0, 1'b0, 5'd1});
    end
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_stat !== 8'd0 || dut_head !== 73'd0) begin
      errors++;
      $display("FAIL single_pop got stat %h head %h exp 0", dut_stat, dut_head);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 17; i++) begin
      drive(0, 32'h100 + 32'(4 * i), 4'hF, 5'(i + 1), $urandom, 0);
      cycle();
      checks++;
      if (dut_stat !== exp_stat()) begin
        errors++;
        $display("FAIL fill_stat[%0d] got %h exp %h", i, dut_stat, exp_stat());
      end
      if (i == 15) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill_full got full=%b ovf=%b exp full=1 ovf=0", full, overflow);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL fill_ovf got ovf=%b cnt=%0d pc=%h exp 1 16 100", overflow, count, out_pc);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_pc;
    drive(0, 32'h200, 4'hF, 5'd7, $urandom, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL fullpp_stat got cnt=%0d ovf=%b full=%b exp 16 1 1", count, overflow, full);
    end
    for (int k = 0; k < 16; k++) begin
      exp_pc = (k < 15) ? 32'h104 + 32'(4 * k) : 32'h200;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || dut_head !== exp_head()) begin
        errors++;
        $display("FAIL drain_pc[%0d] got v=%b pc=%h exp pc=%h", k, out_valid, out_pc, exp_pc);
      end
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty got v=%b cnt=%0d exp 0 0", out_valid, count);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h300 + 32'(4 * i), 4'h3, 5'd9, $urandom, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (count !== 5'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre got cnt=%0d ovf=%b exp 5 1", count, overflow);
    end
    drive(1, 32'h3FC, 4'hF, 5'd3, $urandom, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (dut_stat !== 8'd0) begin
      errors++;
      $display("FAIL clear_stat got %h exp 0", dut_stat);
    end
    repeat (3) cycle();
    checks++;
    if (dut_stat !== 8'd0 || dut_head !== 73'd0) begin
      errors++;
      $display("FAIL clear_hold got stat %h head %h exp 0", dut_stat, dut_head);
    end
  endtask

  task automatic test_r0();
    drive(0, 32'h400, 4'hF, 5'd0, 32'h12345678, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_TRACE_FIFO_X0_FILTER_EN
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL r0_filter got cnt=%0d v=%b exp 0 0", count, out_valid);
    end
`else
    checks++;
    if (count !== 5'd1 || out_valid !== 1'b1 || out_rf_wnum !== 5'd0 || out_pc !== 32'h400) begin
      errors++;
      $display("FAIL r0_capture got cnt=%0d v=%b wnum=%0d pc=%h exp 1 1 0 400",
               count, out_valid, out_rf_wnum, out_pc);
    end
`endif
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic       rdy, clr;
    logic [3:0] wen;
    logic [4:0] wnum;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (dut_stat !== exp_stat() || dut_head !== exp_head()) begin
        errors++;
        $display("FAIL rand[%0d] got stat %h head %h exp stat %h head %h",
                 n, dut_stat, dut_head, exp_stat(), exp_head());
      end
      rdy  = ((n / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 59) == 0);
      wen  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      wnum = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(clr, $urandom, wen, wnum, $urandom, rdy);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h500 + 32'(4 * i), 4'h1, 5'd2, $urandom, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    resetn = 1'b0;
    mq.delete();
    m_ov = 1'b0;
    #1;
    checks++;
    if (dut_stat !== 8'd0 || dut_head !== 73'd0) begin
      errors++;
      $display("FAIL async_reset got stat %h head %h exp 0", dut_stat, dut_head);
    end
    @(negedge clk);
    resetn = 1'b1;
    cycle();
    checks++;
    if (dut_stat !== exp_stat()) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", dut_stat, exp_stat());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_clear();
    test_r0();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Sits directly downstream of the CPU top's writeback trace port (debug_wb_pc / rf_wen / rf_wnum / rf_wdata).
- Captures every retired register-write event into a circular buffer.
- Presents the buffered events on a valid/ready stream to a trace checker or host-visible logger, decoupling the CPU's per-cycle trace from a slower consumer.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of trace entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush of buffer and overflow flag.
- in_pc  input  32  writeback PC from CPU trace.
- in_rf_wen  input  4  writeback byte enables; nonzero means an event.
- in_rf_wnum  input  5  destination register number.
- in_rf_wdata  input  32  written data.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_pc  output  32  head entry PC.
- out_rf_wen  output  4  head entry byte enables.
- out_rf_wnum  output  5  head entry register number.
- out_rf_wdata  output  32  head entry data.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when an event is dropped.

Behaviour:
- Reset (resetn low, asynchronous): rd/wr pointers 0, count 0, out_valid 0, full 0, overflow 0. Storage array is not reset.
- Push condition: in_rf_wen != 4'b0 in a cycle, subject to the optional filter.
- Pop condition: out_valid && out_ready.
- Pointers are log2(DEPTH)+1 bits. The extra MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Show-ahead FIFO: out_* reflect the entry at the read pointer combinationally from storage.
  - When out_valid = 0, out_pc / out_rf_wen / out_rf_wnum / out_rf_wdata are forced to 0.
  - Outputs are deterministic after reset.
- Latency: an event pushed in cycle N is visible with out_valid = 1 in cycle N+1 when the FIFO was empty. No same-cycle bypass.
- count, full and out_valid are registered or derived from registered pointers only. They do not depend combinationally on out_ready.
- Push when not full: entry written at wr_ptr, wr_ptr+1, count+1.
- Pop: rd_ptr+1, count-1.
- Simultaneous push and pop with count between 1 and DEPTH-1: both occur, count unchanged.
- Push when full with pop in the same cycle: push accepted (slot freed this cycle), count stays DEPTH.
- Push when full without pop: event dropped, storage and pointers untouched, overflow <= 1.
- Pop when empty: impossible by definition (out_valid = 0); out_ready is ignored.
- Simultaneous push and pop when empty: push only; pop not possible.
- clear = 1: pointers <= 0, count <= 0, overflow <= 0 at the next edge.
  - clear has priority over a simultaneous push or pop; the pushed event is discarded and overflow is not set.
- overflow stays 1 until clear or reset.
- in_rf_wnum == 0 events are captured unless the optional filter is compiled in.

Optional Feature:
- Macro: WB_TRACE_FIFO_X0_FILTER_EN.
- Defined: push condition becomes (in_rf_wen != 0) && (in_rf_wnum != 0). Writes to r0 are never buffered and can never cause overflow.
- Undefined: r0 writes are buffered like any other event.
- Ports and parameters are identical in both builds.

Decomposition:
- Shared package wb_trace_pkg:
  - typedef trace_entry_t, packed struct {pc[31:0], rf_wen[3:0], rf_wnum[4:0], rf_wdata[31:0]}, 73 bits.
  - localparams TRACE_PC_W = 32, TRACE_WEN_W = 4, TRACE_WNUM_W = 5, TRACE_DATA_W = 32.
- One sub-module: wb_trace_ram.
  - DEPTH x trace_entry_t register array.
  - One synchronous write port, one asynchronous read port, no reset.
  - Pointer, count and flag logic stays in wb_trace_fifo.

Test Plan:
- Reset then idle: resetn low then high, in_rf_wen = 0 for 10 cycles -> out_valid 0, count 0, full 0, overflow 0, all out_* = 0.
- Single event: cycle N in_pc = 0x1C000000, wen = 0xF, wnum = 5, wdata = 0xDEADBEEF, out_ready = 0 -> cycle N+1 out_valid 1 with identical fields, count 1. Assert out_ready for one cycle -> out_valid 0, count 0.
- Fill and overflow: DEPTH = 16, push 17 consecutive events with pc = 0x100 + 4*i, out_ready = 0 -> full 1 after 16 pushes, overflow 1 after the 17th, count 16. Drain shows pc 0x100..0x13C in order; 0x140 is absent.
- Full with simultaneous push/pop: at full, push pc = 0x200 with out_ready = 1 -> count stays 16, overflow unchanged. pc = 0x200 emerges last after draining. Pointer wrap-around is exercised over more than 2 x DEPTH events.
- Clear priority: count 5, overflow 1, then clear = 1 together with a push and out_ready = 1 -> next cycle count 0, out_valid 0, overflow 0. The pushed event never appears.
- Filter build: with WB_TRACE_FIFO_X0_FILTER_EN, push wnum = 0, wen = 0xF -> count stays 0. Same stimulus without the macro -> count 1, out_rf_wnum = 0.
